eth_rx_frame_parser: RTL and testbench
======================================

Name: eth_rx_frame_parser

Overview:
Parametrised GMII receive-side frame parser, the successor to the fixed-format rx frame block. It delineates preamble/SFD, extracts DA, SA and EtherType, and checks FCS with the standard CRC-32. Each frame ends with a one-cycle status record (good/error code/length) and updates saturating frame counters. A delay-aligned copy of the GMII stream is forwarded to the downstream switch datapath.

Parameters:
SA_W, 14, low bits of the 48-bit source MAC reported on o_sa (1..48)
DA_W, 48, low bits of the destination MAC reported on o_da (1..48)
DLY, 5, stream delay in cycles for o_rx_* (>=1)
MIN_LEN, 64, minimum legal frame bytes, DA through FCS
MAX_LEN, 1518, maximum legal frame bytes, DA through FCS
CNT_W, 32, width of the frame counters

Ports:
i_rx_clk  in  1  GMII receive clock; the only clock
i_rst  in  1  reset, asynchronous, active-high
i_rx_dv  in  1  GMII data valid
i_rx_er  in  1  GMII receive error
i_rx_d  in  8  GMII data
o_rx_dv_d / o_rx_er_d / o_rx_d_d  out  1/1/8  inputs delayed exactly DLY cycles
o_fsm_state  out  3  parser state
o_hdr_vld  out  1  one-cycle pulse: o_da/o_sa/o_type freshly captured
o_da  out  DA_W  destination MAC, low bits
o_sa  out  SA_W  source MAC, low bits
o_type  out  16  EtherType/length field
o_stat_vld  out  1  one-cycle pulse: end-of-frame status valid
o_stat_good  out  1  frame has no error
o_stat_err  out  3  0 none, 1 rx_er, 2 truncated, 3 runt, 4 giant, 5 FCS
o_stat_len  out  16  frame bytes, DA through FCS, saturates at 0xFFFF
o_cnt_good / o_cnt_bad  out  CNT_W  saturating frame counters

Behaviour:
- Reset (async assert; sync release internal to flops): every output 0, state IDLE, delay line cleared, armed=0. armed sets the first cycle i_rx_dv is sampled 0. IDLE never leaves until armed, so a frame cut by reset is ignored.
- i_rx_dv=0 is end-of-carrier regardless of i_rx_er (false carrier/extension ignored).
- States: IDLE=0, PRE=1, DA=2, SA=3, TYPE=4, DATA=5, DROP=6.
- IDLE: dv&!er&d==0x55 -> PRE. dv with any other byte or er -> DROP.
- PRE: 0x55 stays, with at most 7 consecutive 0x55 (8th -> DROP). 0xD5 -> DA; clears byte count; CRC register preset to 0xFFFFFFFF. Other byte, er, or dv=0 -> DROP/IDLE with no status.
- DA: 6 bytes, first received = MSB of the 48-bit shift register. SA: 6 bytes, same ordering. TYPE: 2 bytes, first = o_type[15:8]. Then DATA.
- The cycle after the 2nd TYPE byte is sampled, o_hdr_vld=1 for one cycle, and o_da/o_sa/o_type update simultaneously. They hold until the next o_hdr_vld.
- Every dv byte from the first DA byte onward: byte count +1 (saturating) and CRC updated with the team eth_crc32_8d function.
- dv&er in DA..DATA: sets sticky er flag; parsing and counting continue.
- First dv=0 sample in DA..DATA: next cycle o_stat_vld=1 for exactly one cycle, then state IDLE.
- Error priority: rx_er > truncated (ended before DATA) > runt (len<MIN_LEN) > giant (len>MAX_LEN) > FCS (final CRC != 32'hC704DD7B).
- o_stat_good=(err==0). o_stat_* hold until the next o_stat_vld.
- The same cycle as o_stat_vld, o_cnt_good or o_cnt_bad increments by 1; each saturates at all-ones.
- DROP: no status and no counting; dv=0 -> IDLE.
- Back-to-back frames with one idle cycle are accepted; IFG is not enforced. A frame starting the cycle o_stat_vld is high parses normally.
- Delay line is independent of the FSM and never gated or modified.

Test Plan:
- 7x55+D5, DA 01_02_03_04_05_06, SA 00_11_22_33_3A_BC, type 0800, 46 payload bytes, valid FCS -> o_hdr_vld once with o_da=0x010203040506, o_sa=0x3ABC, o_type=0x0800; o_stat_good=1, len=64, err=0, cnt_good=1.
- Same frame with payload byte 20 XOR 0x01 -> good=0, err=5, len=64, cnt_bad=1.
- Same frame with er=1 on payload byte 5 and FCS also corrupted -> err=1 (priority), cnt_bad=1.
- 60-byte frame with valid FCS -> err=3, len=60. 1519-byte frame -> err=4, len=1519.
- dv drops after 10 bytes past SFD -> err=2, len=10, no o_hdr_vld.
- i_rst pulsed mid-DATA -> all outputs 0 immediately, no o_stat_vld; rest of that frame ignored; next frame after dv low -> good=1.
- Checked every cycle: o_rx_* equals the inputs from DLY cycles earlier; frames separated by 1 idle cycle both produce status.

Source files
------------

// File: rtl/eth_rx_frame_parser.sv
// GMII receive frame parser: preamble/SFD delineation, DA/SA/EtherType
// extraction, CRC-32 FCS check, per-frame status record, saturating good/bad
// frame counters and a fixed-latency copy of the raw GMII stream.
module eth_rx_frame_parser #(
  parameter int SA_W    = 14,
  parameter int DA_W    = 48,
  parameter int DLY     = 5,
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518,
  parameter int CNT_W   = 32
) (
  input  logic             i_rx_clk,
  input  logic             i_rst,
  input  logic             i_rx_dv,
  input  logic             i_rx_er,
  input  logic [7:0]       i_rx_d,
  output logic             o_rx_dv_d,
  output logic             o_rx_er_d,
  output logic [7:0]       o_rx_d_d,
  output logic [2:0]       o_fsm_state,
  output logic             o_hdr_vld,
  output logic [DA_W-1:0]  o_da,
  output logic [SA_W-1:0]  o_sa,
  output logic [15:0]      o_type,
  output logic             o_stat_vld,
  output logic             o_stat_good,
  output logic [2:0]       o_stat_err,
  output logic [15:0]      o_stat_len,
  output logic [CNT_W-1:0] o_cnt_good,
  output logic [CNT_W-1:0] o_cnt_bad
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0, ST_PRE = 3'd1, ST_DA = 3'd2, ST_SA = 3'd3,
    ST_TYPE = 3'd4, ST_DATA = 3'd5, ST_DROP = 3'd6
  } state_e;

  typedef enum logic [2:0] {
    ERR_NONE = 3'd0, ERR_RXER = 3'd1, ERR_TRUNC = 3'd2,
    ERR_RUNT = 3'd3, ERR_GIANT = 3'd4, ERR_FCS = 3'd5
  } err_e;

  localparam logic [31:0] CRC_RESIDUE = 32'hC704DD7B;
  localparam logic [15:0] MIN_LEN_L   = 16'(MIN_LEN);
  localparam logic [15:0] MAX_LEN_L   = 16'(MAX_LEN);

  // Byte-wide CRC-32 (poly 0x04C11DB7), GMII bit 0 enters first.
  function automatic logic [31:0] eth_crc32_8d(input logic [31:0] crc,
                                               input logic [7:0]  d);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[31] ^ d[i]) c = {c[30:0], 1'b0} ^ 32'h04C11DB7;
      else              c = {c[30:0], 1'b0};
    end
    return c;
  endfunction

  state_e          state_q, state_d;
  logic            armed_q;
  logic [2:0]      pre_cnt_q;
  logic [2:0]      hdr_cnt_q;
  logic [15:0]     len_q;
  logic [31:0]     crc_q;
  logic            er_flag_q;
  logic [DA_W-1:0] da_sr_q;
  logic [SA_W-1:0] sa_sr_q;
  logic [7:0]      type_hi_q;
  logic [9:0]      dly_q [DLY];

  logic sfd_hit, hdr_done, frame_end, frame_byte;
  err_e err_code;

  // Raw GMII delay line, independent of parsing.
  // NOTE: the delay stages are reset because the forwarded stream must read as idle straight out of reset.
  always_ff @(posedge i_rx_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < DLY; i++) dly_q[i] <= '0;
    end else begin
      dly_q[0] <= {i_rx_dv, i_rx_er, i_rx_d};
      for (int i = 1; i < DLY; i++) dly_q[i] <= dly_q[i-1];
    end
  end

  assign {o_rx_dv_d, o_rx_er_d, o_rx_d_d} = dly_q[DLY-1];
  assign o_fsm_state = state_q;

  // State register and carrier-idle arming after reset.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_rx_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (!i_rx_dv) armed_q <= 1'b1;
    end
  end

  // Next-state logic and per-cycle datapath strobes.
  // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
  always_comb begin
    state_d    = state_q;
    sfd_hit    = 1'b0;
    hdr_done   = 1'b0;
    frame_end  = 1'b0;
    frame_byte = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (armed_q && i_rx_dv)
          state_d = (!i_rx_er && i_rx_d == 8'h55) ? ST_PRE : ST_DROP;
      end
      ST_PRE: begin
        if (!i_rx_dv)                 state_d = ST_IDLE;
        else if (i_rx_er)             state_d = ST_DROP;
        else if (i_rx_d == 8'h55)     state_d = (pre_cnt_q == 3'd7) ? ST_DROP : ST_PRE;
        else if (i_rx_d == 8'hD5) begin
          state_d = ST_DA;
          sfd_hit = 1'b1;
        end else                      state_d = ST_DROP;
      end
      ST_DA, ST_SA, ST_TYPE, ST_DATA: begin
        if (!i_rx_dv) begin
          frame_end = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          frame_byte = 1'b1;
          if (state_q == ST_DA && hdr_cnt_q == 3'd5) state_d = ST_SA;
          if (state_q == ST_SA && hdr_cnt_q == 3'd5) state_d = ST_TYPE;
          if (state_q == ST_TYPE && hdr_cnt_q == 3'd1) begin
            state_d  = ST_DATA;
            hdr_done = 1'b1;
          end
        end
      end
      ST_DROP: begin
        if (!i_rx_dv) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // End-of-frame error code, highest priority first.
  always_comb begin
    err_code = ERR_NONE;
    if (er_flag_q)                 err_code = ERR_RXER;
    else if (state_q != ST_DATA)   err_code = ERR_TRUNC;
    else if (len_q < MIN_LEN_L)    err_code = ERR_RUNT;
    else if (len_q > MAX_LEN_L)    err_code = ERR_GIANT;
    else if (crc_q != CRC_RESIDUE) err_code = ERR_FCS;
  end

  // Frame datapath: counts, CRC, header capture, status and counters.
  always_ff @(posedge i_rx_clk or posedge i_rst) begin
    if (i_rst) begin
      pre_cnt_q   <= '0;
      hdr_cnt_q   <= '0;
      len_q       <= '0;
      crc_q       <= '0;
      er_flag_q   <= 1'b0;
      da_sr_q     <= '0;
      sa_sr_q     <= '0;
      type_hi_q   <= '0;
      o_hdr_vld   <= 1'b0;
      o_da        <= '0;
      o_sa        <= '0;
      o_type      <= '0;
      o_stat_vld  <= 1'b0;
      o_stat_good <= 1'b0;
      o_stat_err  <= '0;
      o_stat_len  <= '0;
      o_cnt_good  <= '0;
      o_cnt_bad   <= '0;
    end else begin
      if (state_d == ST_PRE)
        pre_cnt_q <= (state_q == ST_PRE) ? pre_cnt_q + 3'd1 : 3'd1;

      if (sfd_hit) begin
        hdr_cnt_q <= '0;
        len_q     <= '0;
        crc_q     <= 32'hFFFF_FFFF;
        er_flag_q <= 1'b0;
      end else if (frame_byte) begin
        hdr_cnt_q <= (state_d != state_q) ? 3'd0 : hdr_cnt_q + 3'd1;
        if (len_q != 16'hFFFF) len_q <= len_q + 16'd1;
        crc_q <= eth_crc32_8d(crc_q, i_rx_d);
        if (i_rx_er) er_flag_q <= 1'b1;
        if (state_q == ST_DA) da_sr_q <= DA_W'({da_sr_q, i_rx_d});
        if (state_q == ST_SA) sa_sr_q <= SA_W'({sa_sr_q, i_rx_d});
        if (state_q == ST_TYPE && hdr_cnt_q == 3'd0) type_hi_q <= i_rx_d;
      end

      o_hdr_vld <= hdr_done;
      if (hdr_done) begin
        o_da   <= da_sr_q;
        o_sa   <= sa_sr_q;
        o_type <= {type_hi_q, i_rx_d};
      end

      o_stat_vld <= frame_end;
      if (frame_end) begin
        o_stat_good <= (err_code == ERR_NONE);
        o_stat_err  <= err_code;
        o_stat_len  <= len_q;
        if (err_code == ERR_NONE) begin
          if (o_cnt_good != {CNT_W{1'b1}}) o_cnt_good <= o_cnt_good + CNT_W'(1);
        end else begin
          if (o_cnt_bad != {CNT_W{1'b1}}) o_cnt_bad <= o_cnt_bad + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_eth_rx_frame_parser.sv
// Directed bench for eth_rx_frame_parser: builds frames with a reflected
// CRC-32 FCS, drives them on GMII and checks header, status, counters and the
// delayed stream copy.
module tb_eth_rx_frame_parser;

  localparam int SA_W    = 14;
  localparam int DA_W    = 48;
  localparam int DLY     = 5;
  localparam int MIN_LEN = 64;
  localparam int MAX_LEN = 1518;
  localparam int CNT_W   = 32;

  logic             i_rx_clk = 1'b0;
  logic             i_rst    = 1'b1;
  logic             i_rx_dv  = 1'b0;
  logic             i_rx_er  = 1'b0;
  logic [7:0]       i_rx_d   = 8'h00;
  logic             o_rx_dv_d, o_rx_er_d;
  logic [7:0]       o_rx_d_d;
  logic [2:0]       o_fsm_state;
  logic             o_hdr_vld;
  logic [DA_W-1:0]  o_da;
  logic [SA_W-1:0]  o_sa;
  logic [15:0]      o_type;
  logic             o_stat_vld, o_stat_good;
  logic [2:0]       o_stat_err;
  logic [15:0]      o_stat_len;
  logic [CNT_W-1:0] o_cnt_good, o_cnt_bad;

  eth_rx_frame_parser #(
    .SA_W(SA_W), .DA_W(DA_W), .DLY(DLY),
    .MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN), .CNT_W(CNT_W)
  ) dut (
    .i_rx_clk(i_rx_clk), .i_rst(i_rst),
    .i_rx_dv(i_rx_dv), .i_rx_er(i_rx_er), .i_rx_d(i_rx_d),
    .o_rx_dv_d(o_rx_dv_d), .o_rx_er_d(o_rx_er_d), .o_rx_d_d(o_rx_d_d),
    .o_fsm_state(o_fsm_state), .o_hdr_vld(o_hdr_vld),
    .o_da(o_da), .o_sa(o_sa), .o_type(o_type),
    .o_stat_vld(o_stat_vld), .o_stat_good(o_stat_good),
    .o_stat_err(o_stat_err), .o_stat_len(o_stat_len),
    .o_cnt_good(o_cnt_good), .o_cnt_bad(o_cnt_bad)
  );

  always #5 i_rx_clk = ~i_rx_clk;

  int n_tests    = 0;
  int n_fail     = 0;
  int hdr_seen   = 0;
  int stat_seen  = 0;
  logic prev_stat = 1'b0;
  logic prev_hdr  = 1'b0;
  logic [9:0] hist [$];
  logic [7:0] fb [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  // Per-cycle monitor: delayed stream, pulse widths, event counts.
  always @(posedge i_rx_clk) begin
    if (i_rst) begin
      hist = {};
      for (int i = 0; i < DLY - 1; i++) hist.push_front(10'd0);
      prev_stat = 1'b0;
      prev_hdr  = 1'b0;
    end else begin
      hist.push_front({i_rx_dv, i_rx_er, i_rx_d});
      #1;
      check("rx_delay", {o_rx_dv_d, o_rx_er_d, o_rx_d_d}, hist[DLY-1]);
      if (hist.size() > DLY) void'(hist.pop_back());
      check("stat_vld_one_cycle", o_stat_vld & prev_stat, 0);
      check("hdr_vld_one_cycle", o_hdr_vld & prev_hdr, 0);
      if (o_stat_vld) stat_seen++;
      if (o_hdr_vld)  hdr_seen++;
      prev_stat = o_stat_vld;
      prev_hdr  = o_hdr_vld;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, required $finish before it");
    $fatal(1, "watchdog");
  end

  task automatic drive(input logic dv, input logic er, input logic [7:0] d);
    @(negedge i_rx_clk);
    i_rx_dv = dv;
    i_rx_er = er;
    i_rx_d  = d;
  endtask

  // Frame = DA 01..06, SA 00_11_22_33_3A_BC, type 0800, payload, FCS.
  task automatic mk_frame(input int pay_len);
    logic [31:0] crc;
    logic [31:0] fcs;
    logic [7:0]  b;
    fb = {};
    fb.push_back(8'h01); fb.push_back(8'h02); fb.push_back(8'h03);
    fb.push_back(8'h04); fb.push_back(8'h05); fb.push_back(8'h06);
    fb.push_back(8'h00); fb.push_back(8'h11); fb.push_back(8'h22);
    fb.push_back(8'h33); fb.push_back(8'h3A); fb.push_back(8'hBC);
    fb.push_back(8'h08); fb.push_back(8'h00);
    for (int i = 0; i < pay_len; i++) begin
      b = 8'(i * 7 + 3);
      fb.push_back(b);
    end
    crc = 32'hFFFF_FFFF;
    for (int i = 0; i < fb.size(); i++) begin
      crc = crc ^ {24'd0, fb[i]};
      for (int k = 0; k < 8; k++)
        crc = crc[0] ? ((crc >> 1) ^ 32'hEDB88320) : (crc >> 1);
    end
    fcs = ~crc;
    fb.push_back(fcs[7:0]);   fb.push_back(fcs[15:8]);
    fb.push_back(fcs[23:16]); fb.push_back(fcs[31:24]);
  endtask

  task automatic send_frame(input int n_pre, input int n_bytes, input int er_idx);
    for (int i = 0; i < n_pre; i++) drive(1'b1, 1'b0, 8'h55);
    drive(1'b1, 1'b0, 8'hD5);
    for (int i = 0; i < n_bytes; i++) drive(1'b1, (i == er_idx), fb[i]);
    drive(1'b0, 1'b0, 8'h00);
  endtask

  task automatic wait_stat(input int target);
    int k;
    k = 0;
    while (stat_seen < target && k < 40) begin
      @(posedge i_rx_clk);
      #2;
      k++;
    end
    check("stat_arrived", stat_seen, target);
  endtask

  int s0, h0;

  initial begin
    // Reset state
    repeat (3) @(negedge i_rx_clk);
    check("rst_state", o_fsm_state, 0);
    check("rst_stat_vld", o_stat_vld, 0);
    check("rst_cnt_good", o_cnt_good, 0);
    check("rst_rx_dv_d", o_rx_dv_d, 0);
    i_rst = 1'b0;
    drive(1'b0, 1'b0, 8'h00);
    drive(1'b0, 1'b0, 8'h00);

    // Good 64-byte frame
    mk_frame(46);
    s0 = stat_seen; h0 = hdr_seen;
    send_frame(7, fb.size(), -1);
    wait_stat(s0 + 1);
    check("good_hdr_once", hdr_seen, h0 + 1);
    check("good_da", o_da, 48'h010203040506);
    check("good_sa", o_sa, 14'h3ABC);
    check("good_type", o_type, 16'h0800);
    check("good_stat_good", o_stat_good, 1);
    check("good_err", o_stat_err, 0);
    check("good_len", o_stat_len, 64);
    check("good_cnt_good", o_cnt_good, 1);
    check("good_cnt_bad", o_cnt_bad, 0);

    // FCS error: payload byte 20 flipped
    mk_frame(46);
    fb[14+20] = fb[14+20] ^ 8'h01;
    s0 = stat_seen;
    send_frame(7, fb.size(), -1);
    wait_stat(s0 + 1);
    check("fcs_good", o_stat_good, 0);
    check("fcs_err", o_stat_err, 5);
    check("fcs_len", o_stat_len, 64);
    check("fcs_cnt_bad", o_cnt_bad, 1);

    // rx_er on payload byte 5 plus bad FCS: rx_er wins
    mk_frame(46);
    fb[63] = fb[63] ^ 8'hFF;
    s0 = stat_seen;
    send_frame(7, fb.size(), 14 + 5);
    wait_stat(s0 + 1);
    check("rxer_err", o_stat_err, 1);
    check("rxer_cnt_bad", o_cnt_bad, 2);

    // Runt: 60 bytes, valid FCS
    mk_frame(42);
    s0 = stat_seen;
    send_frame(7, fb.size(), -1);
    wait_stat(s0 + 1);
    check("runt_err", o_stat_err, 3);
    check("runt_len", o_stat_len, 60);

    // Giant: 1519 bytes
    mk_frame(1501);
    s0 = stat_seen;
    send_frame(7, fb.size(), -1);
    wait_stat(s0 + 1);
    check("giant_err", o_stat_err, 4);
    check("giant_len", o_stat_len, 1519);
    check("giant_cnt_bad", o_cnt_bad, 4);

    // Truncated after 10 bytes: no header pulse
    mk_frame(46);
    s0 = stat_seen; h0 = hdr_seen;
    send_frame(7, 10, -1);
    wait_stat(s0 + 1);
    check("trunc_err", o_stat_err, 2);
    check("trunc_len", o_stat_len, 10);
    check("trunc_good", o_stat_good, 0);
    check("trunc_no_hdr", hdr_seen, h0);
    check("trunc_cnt_bad", o_cnt_bad, 5);

    // Eight 0x55 in a row: dropped, no status
    s0 = stat_seen;
    for (int i = 0; i < 8; i++) drive(1'b1, 1'b0, 8'h55);
    @(posedge i_rx_clk); #2;
    check("pre8_drop_state", o_fsm_state, 6);
    drive(1'b1, 1'b0, 8'hD5);
    for (int i = 0; i < fb.size(); i++) drive(1'b1, 1'b0, fb[i]);
    drive(1'b0, 1'b0, 8'h00);
    repeat (4) drive(1'b0, 1'b0, 8'h00);
    check("pre8_no_stat", stat_seen, s0);
    check("pre8_idle", o_fsm_state, 0);

    // Back-to-back frames, one idle cycle apart
    mk_frame(46);
    s0 = stat_seen;
    send_frame(7, fb.size(), -1);
    send_frame(7, fb.size(), -1);
    wait_stat(s0 + 2);
    check("b2b_good", o_stat_good, 1);
    check("b2b_cnt_good", o_cnt_good, 3);

    // Reset in the middle of DATA
    mk_frame(46);
    s0 = stat_seen;
    for (int i = 0; i < 7; i++) drive(1'b1, 1'b0, 8'h55);
    drive(1'b1, 1'b0, 8'hD5);
    for (int i = 0; i < 30; i++) drive(1'b1, 1'b0, fb[i]);
    @(negedge i_rx_clk);
    i_rst  = 1'b1;
    i_rx_d = fb[30];
    #1;
    check("mrst_state", o_fsm_state, 0);
    check("mrst_cnt_good", o_cnt_good, 0);
    check("mrst_cnt_bad", o_cnt_bad, 0);
    check("mrst_stat_good", o_stat_good, 0);
    check("mrst_stat_len", o_stat_len, 0);
    check("mrst_da", o_da, 0);
    check("mrst_type", o_type, 0);
    check("mrst_rx_dv_d", o_rx_dv_d, 0);
    drive(1'b1, 1'b0, fb[31]);
    drive(1'b1, 1'b0, fb[32]);
    drive(1'b1, 1'b0, fb[33]);
    i_rst = 1'b0;
    for (int i = 34; i < fb.size(); i++) drive(1'b1, 1'b0, fb[i]);
    @(posedge i_rx_clk); #2;
    check("mrst_ignored_state", o_fsm_state, 0);
    drive(1'b0, 1'b0, 8'h00);
    repeat (3) drive(1'b0, 1'b0, 8'h00);
    check("mrst_no_stat", stat_seen, s0);
    s0 = stat_seen;
    send_frame(7, fb.size(), -1);
    wait_stat(s0 + 1);
    check("post_rst_good", o_stat_good, 1);
    check("post_rst_len", o_stat_len, 64);
    check("post_rst_cnt_good", o_cnt_good, 1);
    check("post_rst_cnt_bad", o_cnt_bad, 0);

    repeat (3) drive(1'b0, 1'b0, 8'h00);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
